// File: rtl/mips_instruction_loader_pkg.sv
// Shared constants and types for the instruction memory and its byte-stream loader.
package mips_instruction_loader_pkg;

    localparam int Instruction_Width          = 32;
    localparam int Instruction_Mem_Addr_Width = 4;
    localparam int Instruction_Mem_Depth      = 16;
    localparam int Loader_Count_Width         = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        WORD,
        WRITE,
        DONE
    } loader_state_e;

endpackage

// File: rtl/mips_loader_word_assembler.sv
// Big-endian word assembly: bytes shift in from the right, last_byte flags the final byte slot.
module mips_loader_word_assembler
    import mips_instruction_loader_pkg::*;
#(
    parameter int DATA_W = Instruction_Width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              last_byte
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    assign last_byte = (idx_q == IDX_W'(NB - 1));
    assign word      = word_q;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (shift_en) begin
            word_d = (word_q << 8) | DATA_W'(byte_in);
            idx_d  = last_byte ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/mips_instruction_loader.sv
// Loads a length-prefixed byte stream into instruction memory from address 0 while holding the core.
module mips_instruction_loader
    import mips_instruction_loader_pkg::*;
#(
    parameter int DATA_W = Instruction_Width,
    parameter int ADDR_W = Instruction_Mem_Addr_Width,
    parameter int DEPTH  = Instruction_Mem_Depth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_len,
    output logic [15:0]       words_written
);

    localparam logic [Loader_Count_Width:0] DEPTH_L = (Loader_Count_Width + 1)'(DEPTH);

    loader_state_e state_q, state_d;
    logic [Loader_Count_Width-1:0] count_q, count_d;
    logic [15:0]       words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;
    logic              w_en_q, w_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              xfer;
    logic              asm_clr;
    logic              asm_shift;
    logic              asm_last;
    logic [DATA_W-1:0] asm_word;

    assign xfer      = in_valid && in_ready_q;
    assign asm_shift = xfer && (state_q == WORD);

    mips_loader_word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr),
        .shift_en  (asm_shift),
        .byte_in   (in_data),
        .word      (asm_word),
        .last_byte (asm_last)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        words_d = words_q;
        addr_d  = addr_q;
        err_d   = err_q;
        asm_clr = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = LEN_HI;
                err_d   = 1'b0;
                words_d = '0;
                addr_d  = '0;
                asm_clr = 1'b1;
            end
            LEN_HI: if (xfer) begin
                count_d = {in_data, count_q[7:0]};
                state_d = LEN_LO;
            end
            LEN_LO: if (xfer) begin
                count_d = {count_q[15:8], in_data};
                if (count_d == '0) begin
                    state_d = DONE;
                end else if ({1'b0, count_d} > DEPTH_L) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = WORD;
                end
            end
            WORD: if (xfer && asm_last) state_d = WRITE;
            WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                words_d = words_q + 16'd1;
                state_d = (words_d == count_q) ? DONE : WORD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        in_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == WORD);
        w_en_d     = (state_d == WRITE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            words_q    <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            w_en_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            words_q    <= words_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            w_en_q     <= w_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign w_en          = w_en_q;
    assign w_addr        = addr_q;
    assign w_data        = asm_word;
    assign busy          = busy_q;
    assign cpu_hold      = busy_q;
    assign done          = done_q;
    assign err_len       = err_q;
    assign words_written = words_q;

endmodule
